demux4_reg: RTL and testbench

//   1-to-4 registered demultiplexer: inverse of the 4:1 select path. Steers one

---
 rtl/demux4_reg.sv | 140 ++++++++++++++
 tb/tb_demux4_reg.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/demux4_reg.sv
// ---------------------------------------------------------------------------
// demux4_reg
//
// 1-to-4 registered demultiplexer. A single valid/ready input stream is
// steered by in_sel into one of four output channels. Each channel has a
// one-entry output register with its own valid/ready handshake, so the four
// consumers drain independently of each other. Each channel also keeps a
// modulo-2^CNT_W count of the words it has accepted.
//
// Parameters
//   WIDTH  data width of in_data and of each output channel
//   CNT_W  width of each per-channel accepted-word counter
//
// Ports
//   clk        single clock; all state updates on posedge
//   rst        synchronous, active-high reset
//   in_data    word to route
//   in_sel     target channel (0..3)
//   in_valid   in_data/in_sel are valid this cycle
//   in_ready   selected channel can take a word this cycle (combinational)
//   out_data   channel k at bits [k*WIDTH +: WIDTH]
//   out_valid  bit k: channel k holds a word
//   out_ready  bit k: consumer k takes the word this cycle
//   cnt        channel k accepted-word count at bits [k*CNT_W +: CNT_W]
// ---------------------------------------------------------------------------
module demux4_reg #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [1:0]         in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [4*WIDTH-1:0] out_data,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready,
    output logic [4*CNT_W-1:0] cnt
);

    typedef enum logic {
        CH_EMPTY = 1'b0,
        CH_FULL  = 1'b1
    } ch_state_e;

    ch_state_e        state_q [4];
    ch_state_e        state_d [4];
    logic [WIDTH-1:0] data_q  [4];
    logic [WIDTH-1:0] data_d  [4];
    logic [CNT_W-1:0] cnt_q   [4];
    logic [CNT_W-1:0] cnt_d   [4];

    logic [3:0] sel_oh;
    logic [3:0] load;
    logic [3:0] drain;
    logic       acc;

    // Only the selected channel gates the input: a full channel with a
    // stalled consumer blocks the stream even when the others are empty.
    // A channel being drained this cycle can take a new word in the same
    // cycle, which gives one word per clock per channel with no bubble.
    always_comb begin : input_handshake
        in_ready = (state_q[in_sel] == CH_EMPTY) | out_ready[in_sel];
        acc      = in_valid & in_ready & ~rst;
    end

    // acc is 0 whenever in_valid is 0, so a garbage in_sel with no valid
    // word cannot produce a load.
    always_comb begin : sel_decode
        sel_oh         = '0;
        sel_oh[in_sel] = 1'b1;
        load           = sel_oh & {4{acc}};
    end

    always_comb begin : drain_decode
        drain = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            drain[k] = (state_q[k] == CH_FULL) & out_ready[k];
        end
    end

    // Per-channel next state. Load has priority over drain so that a
    // simultaneous drain+load keeps the channel full with the new word.
    always_comb begin : channel_next
        for (int unsigned k = 0; k < 4; k++) begin
            state_d[k] = state_q[k];
            data_d[k]  = data_q[k];
            cnt_d[k]   = cnt_q[k];

            unique case (state_q[k])
                CH_EMPTY: begin
                    if (load[k]) begin
                        state_d[k] = CH_FULL;
                    end
                end
                CH_FULL: begin
                    if (drain[k] && !load[k]) begin
                        state_d[k] = CH_EMPTY;
                    end
                end
                default: state_d[k] = CH_EMPTY;
            endcase

            // Data is left in place on drain; only a load overwrites it.
            if (load[k]) begin
                data_d[k] = in_data;
                cnt_d[k]  = cnt_q[k] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin : channel_regs
        if (rst) begin
            for (int unsigned k = 0; k < 4; k++) begin
                state_q[k] <= CH_EMPTY;
                data_q[k]  <= '0;
                cnt_q[k]   <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < 4; k++) begin
                state_q[k] <= state_d[k];
                data_q[k]  <= data_d[k];
                cnt_q[k]   <= cnt_d[k];
            end
        end
    end

    always_comb begin : output_pack
        out_data  = '0;
        out_valid = '0;
        cnt       = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            out_valid[k]               = (state_q[k] == CH_FULL);
            out_data[k*WIDTH +: WIDTH] = data_q[k];
            cnt[k*CNT_W +: CNT_W]      = cnt_q[k];
        end
    end

endmodule

// File: tb/tb_demux4_reg.sv
module tb_demux4_reg;

    localparam int W  = 32;
    localparam int CW = 16;

    logic           clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic [W-1:0]   in_data;
    logic [1:0]     in_sel;
    logic           in_valid;
    logic [3:0]     out_ready;

    logic           in_ready,  in_ready4;
    logic [4*W-1:0] out_data,  out_data4;
    logic [3:0]     out_valid, out_valid4;
    logic [4*CW-1:0] cnt;
    logic [15:0]    cnt4;

    demux4_reg #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .cnt(cnt)
    );

    // Narrow-counter instance, driven identically, to observe wraparound.
    demux4_reg #(.WIDTH(W), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready4), .out_data(out_data4),
        .out_valid(out_valid4), .out_ready(out_ready), .cnt(cnt4)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: per channel, is a word held, what word, how many accepted.
    bit          mv [4];
    logic [W-1:0] md [4];
    int unsigned mc [4];

    function automatic logic [3:0] m_valid();
        logic [3:0] r = '0;
        for (int k = 0; k < 4; k++) r[k] = mv[k];
        return r;
    endfunction

    function automatic logic [4*W-1:0] m_data();
        logic [4*W-1:0] r = '0;
        for (int k = 0; k < 4; k++) r[k*W +: W] = md[k];
        return r;
    endfunction

    function automatic logic [4*CW-1:0] m_cnt();
        logic [4*CW-1:0] r = '0;
        for (int k = 0; k < 4; k++) r[k*CW +: CW] = CW'(mc[k] % 65536);
        return r;
    endfunction

    function automatic logic [15:0] m_cnt4();
        logic [15:0] r = '0;
        for (int k = 0; k < 4; k++) r[k*4 +: 4] = 4'(mc[k] % 16);
        return r;
    endfunction

    // One clock: drive inputs after negedge, check in_ready before the edge,
    // advance the model at the edge, check all outputs 1 time unit later.
    task automatic cycle(input bit r, input bit v, input logic [1:0] s,
                         input logic [W-1:0] d, input logic [3:0] ordy,
                         output bit rdy_seen);
        bit exp_rdy;
        @(negedge clk);
        rst = r; in_valid = v; in_sel = s; in_data = d; out_ready = ordy;
        #1;
        exp_rdy = !mv[s] || ordy[s];
        chk("in_ready", 128'(in_ready), 128'(exp_rdy));
        chk("in_ready_c4", 128'(in_ready4), 128'(exp_rdy));
        rdy_seen = in_ready;
        @(posedge clk);
        if (r) begin
            for (int k = 0; k < 4; k++) begin mv[k] = 0; md[k] = '0; mc[k] = 0; end
        end else begin
            for (int k = 0; k < 4; k++) if (mv[k] && ordy[k]) mv[k] = 0;
            if (v && exp_rdy) begin
                mv[s] = 1; md[s] = d; mc[s] = mc[s] + 1;
            end
        end
        #1;
        chk("out_valid", 128'(out_valid), 128'(m_valid()));
        chk("out_data", 128'(out_data), 128'(m_data()));
        chk("cnt", 128'(cnt), 128'(m_cnt()));
        chk("out_valid_c4", 128'(out_valid4), 128'(m_valid()));
        chk("cnt_c4", 128'(cnt4), 128'(m_cnt4()));
    endtask

    typedef struct {
        bit         r;
        bit         v;
        logic [1:0] s;
        logic [W-1:0] d;
        logic [3:0] ordy;
        bit         exp_rdy;
        logic [3:0] exp_vld;
    } vec_t;

    vec_t tbl[$];
    bit   rdy;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sel = 2'd0; in_data = '0; out_ready = '0;
        for (int k = 0; k < 4; k++) begin mv[k] = 0; md[k] = '0; mc[k] = 0; end

        // reset from unknown state, then check reset values directly
        cycle(1, 0, 2'd0, '0, 4'b0000, rdy);
        cycle(1, 0, 2'd0, '0, 4'b0000, rdy);
        chk("reset_valid", 128'(out_valid), 128'(0));
        chk("reset_cnt", 128'(cnt), 128'(0));
        chk("reset_data", 128'(out_data), 128'(0));

        //               r  v  sel  data          ordy     rdy vld_after
        tbl.push_back('{1'b0, 1'b1, 2'd2, 32'hDEADBEEF, 4'b0000, 1'b1, 4'b0100}); // load ch2
        tbl.push_back('{1'b0, 1'b0, 2'd0, 32'h0,        4'b0100, 1'b1, 4'b0000}); // drain ch2
        tbl.push_back('{1'b0, 1'b1, 2'd1, 32'h22,       4'b0000, 1'b1, 4'b0010}); // fill ch1
        tbl.push_back('{1'b0, 1'b1, 2'd1, 32'h11,       4'b0000, 1'b0, 4'b0010}); // ch1 blocks
        tbl.push_back('{1'b0, 1'b1, 2'd3, 32'h33,       4'b0000, 1'b1, 4'b1010}); // ch3 still free
        tbl.push_back('{1'b0, 1'b1, 2'd0, 32'hA0,       4'b0000, 1'b1, 4'b1011}); // fill ch0
        tbl.push_back('{1'b0, 1'b0, 2'd1, 32'h0,        4'b1001, 1'b0, 4'b0010}); // drain ch0+ch3
        tbl.push_back('{1'b0, 1'b0, 2'd0, 32'h0,        4'b1101, 1'b1, 4'b0010}); // ready on empty ch
        tbl.push_back('{1'b0, 1'b1, 2'd0, 32'hB0,       4'b0000, 1'b1, 4'b0011});
        tbl.push_back('{1'b0, 1'b1, 2'd2, 32'hB2,       4'b0000, 1'b1, 4'b0111});
        tbl.push_back('{1'b0, 1'b1, 2'd3, 32'hB3,       4'b0000, 1'b1, 4'b1111}); // all full
        tbl.push_back('{1'b1, 1'b1, 2'd0, 32'hCC,       4'b0001, 1'b1, 4'b0000}); // reset wins

        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].r, tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].ordy, rdy);
            chk($sformatf("vec%0d_rdy", i), 128'(rdy), 128'(tbl[i].exp_rdy));
            chk($sformatf("vec%0d_vld", i), 128'(out_valid), 128'(tbl[i].exp_vld));
            if (i == 0) begin
                chk("first_ch2_data", 128'(out_data[2*W +: W]), 128'(32'hDEADBEEF));
                chk("first_cnt", 128'(cnt), 128'(64'h0000_0001_0000_0000));
            end
        end
        chk("rst_cycle_cnt", 128'(cnt), 128'(0));
        chk("rst_cycle_data", 128'(out_data), 128'(0));

        // ch0 full, consumer always ready, stream 1..8: no bubble
        cycle(0, 1, 2'd0, 32'd0, 4'b0000, rdy);
        for (int i = 1; i <= 8; i++) begin
            cycle(0, 1, 2'd0, W'(i), 4'b0001, rdy);
            chk("stream_rdy", 128'(rdy), 128'(1));
            chk("stream_vld0", 128'(out_valid[0]), 128'(1));
            chk("stream_data0", 128'(out_data[W-1:0]), 128'(i));
        end
        // one word preloaded + eight streamed
        chk("stream_cnt0", 128'(cnt[CW-1:0]), 128'(9));

        // 16 accepts to ch1: narrow counter wraps 15 -> 0
        cycle(1, 0, 2'd0, '0, 4'b0000, rdy);
        for (int i = 0; i < 16; i++) begin
            cycle(0, 1, 2'd1, W'(32'h100 + i), 4'b0010, rdy);
            if (i == 14) chk("wrap_cnt1_15", 128'(cnt4[7:4]), 128'(15));
        end
        chk("wrap_cnt1_0", 128'(cnt4), 128'(0));
        chk("wide_cnt1_16", 128'(cnt), 128'(64'h0000_0000_0010_0000));

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 49) == 0, 1'($urandom), 2'($urandom),
                  $urandom, 4'($urandom), rdy);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
